// File: rtl/sme_pkg.sv
// Shared types and constants for the string-match engine host-side sender.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sme_pkg;

  localparam int CHAR_W   = 8;
  localparam int STR_MAX  = 32;
  localparam int PAT_MAX  = 8;
  localparam int NPAT_MAX = 4;   // pat_len / ld_pidx encodings give room for four slots

  // Characters with special meaning to the engine's pattern matcher
  localparam logic [CHAR_W-1:0] CH_BOL = 8'h5E;  // '^'
  localparam logic [CHAR_W-1:0] CH_EOL = 8'h24;  // '$'
  localparam logic [CHAR_W-1:0] CH_ANY = 8'h2E;  // '.'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_STR,
    ST_SEND_PAT,
    ST_WAIT_RES,
    ST_DONE
  } state_t;

  // Job configuration captured when a start is accepted
  typedef struct packed {
    logic [5:0]  str_len;
    logic [2:0]  num_pat;
    logic [15:0] pat_len;   // slot k at [4k+3:4k]
  } job_cfg_t;

  // One forwarded engine result
  typedef struct packed {
    logic       match;
    logic [4:0] index;
    logic [1:0] pidx;
    logic       timeout;
  } result_t;

  // A job is legal when the string and every used pattern slot are non-empty
  // and within their buffers, and the pattern count fits the configured slots.
  function automatic logic cfg_legal(input job_cfg_t cfg, input int str_max,
                                     input int pat_max, input int npat);
    logic ok;
    ok = (cfg.str_len != 6'd0) && (int'(cfg.str_len) <= str_max) &&
         (cfg.num_pat != 3'd0) && (int'(cfg.num_pat) <= npat);
    for (int k = 0; k < NPAT_MAX; k++) begin
      if (k < int'(cfg.num_pat)) begin
        if ((cfg.pat_len[4*k +: 4] == 4'd0) || (int'(cfg.pat_len[4*k +: 4]) > pat_max)) begin
          ok = 1'b0;
        end
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/sme_char_buf.sv
// Character register file: one synchronous write port, one combinational read mux.
// Latency: write visible on the cycle after we; read is combinational.
// Backpressure: none; every write is taken.
// Ports: clk; we/waddr/wdata write port; raddr -> rdata read port.
// Contents are not reset; the host loads them before a job uses them.
module sme_char_buf
  import sme_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [CHAR_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [CHAR_W-1:0] rdata
);

  logic [CHAR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sme_job_sender.sv
// Host-side job sender: streams one string and up to NPAT patterns to the match engine, forwards results.
// Latency: first string char the cycle after start; result one cycle after the engine's valid.
// Backpressure: none toward the engine; waits in WAIT_RES for valid; loads and starts ignored while busy.
// Ports: ld_* host load bus; start/str_len/num_pat/pat_len job request; chardata/isstring/ispattern
//   to engine; valid/match/match_index from engine; res_* result pulse; busy/done/cfg_err status.
// Option: define SME_TIMEOUT_EN to add a per-pattern watchdog of TIMEOUT cycles in WAIT_RES.
module sme_job_sender
  import sme_pkg::*;
#(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int NPAT    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_we,
  input  logic              ld_sel,
  input  logic [1:0]        ld_pidx,
  input  logic [4:0]        ld_addr,
  input  logic [7:0]        ld_data,
  input  logic              start,
  input  logic [5:0]        str_len,
  input  logic [2:0]        num_pat,
  input  logic [15:0]       pat_len,
  output logic [7:0]        chardata,
  output logic              isstring,
  output logic              ispattern,
  input  logic              valid,
  input  logic              match,
  input  logic [4:0]        match_index,
  output logic              res_valid,
  output logic              res_match,
  output logic [4:0]        res_index,
  output logic [1:0]        res_pidx,
  output logic              res_timeout,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  state_t            state_q, state_d;
  job_cfg_t          cfg_q, cfg_d, start_cfg;
  logic [4:0]        cnt_q, cnt_d;
  logic [1:0]        pidx_q, pidx_d;
  result_t           res_q, res_d;
  logic              res_valid_d, done_d, busy_d, cfg_err_d;
  logic              isstring_d, ispattern_d;
  logic [CHAR_W-1:0] chardata_d, str_rdata, pat_rdata;
  logic [3:0]        cur_plen;
  logic              last_pat;
  logic              ld_ok;

`ifdef SME_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  assign start_cfg = '{str_len: str_len, num_pat: num_pat, pat_len: pat_len};
  assign cur_plen  = cfg_q.pat_len[{pidx_q, 2'b00} +: 4];
  assign last_pat  = ({1'b0, pidx_q} == (cfg_q.num_pat - 3'd1));
  // DONE lasts one cycle with busy already low, so the host may load there too
  assign ld_ok     = (state_q == ST_IDLE) || (state_q == ST_DONE);

  // Buffers are read at the next-state address so the char lands in the
  // output register on the same edge that moves the FSM.
  sme_char_buf #(.DEPTH(STR_MAX), .AW(5)) u_str_buf (
    .clk   (clk),
    .we    (ld_we && ld_ok && !ld_sel),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (cnt_d),
    .rdata (str_rdata)
  );

  sme_char_buf #(.DEPTH(NPAT * PAT_MAX), .AW(5)) u_pat_buf (
    .clk   (clk),
    .we    (ld_we && ld_ok && ld_sel && (int'(ld_pidx) < NPAT)),
    .waddr ({ld_pidx, ld_addr[2:0]}),
    .wdata (ld_data),
    .raddr ({pidx_d, cnt_d[2:0]}),
    .rdata (pat_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    cnt_d       = cnt_q;
    pidx_d      = pidx_q;
    res_d       = res_q;
    res_valid_d = 1'b0;
    cfg_err_d   = 1'b0;
`ifdef SME_TIMEOUT_EN
    wd_d        = wd_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_legal(start_cfg, STR_MAX, PAT_MAX, NPAT)) begin
            cfg_d   = start_cfg;
            cnt_d   = 5'd0;
            state_d = ST_SEND_STR;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      ST_SEND_STR: begin
        // Straight into pattern 0 with no idle cycle: the engine leaves string
        // mode as soon as isstring drops.
        if ({1'b0, cnt_q} == (cfg_q.str_len - 6'd1)) begin
          cnt_d   = 5'd0;
          pidx_d  = 2'd0;
          state_d = ST_SEND_PAT;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      ST_SEND_PAT: begin
        if (cnt_q == {1'b0, cur_plen - 4'd1}) begin
          cnt_d   = 5'd0;
          state_d = ST_WAIT_RES;
`ifdef SME_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      ST_WAIT_RES: begin
        if (valid) begin
          res_valid_d = 1'b1;
          res_d       = '{match: match, index: match_index, pidx: pidx_q, timeout: 1'b0};
          if (last_pat) begin
            state_d = ST_DONE;
          end else begin
            pidx_d  = pidx_q + 2'd1;
            cnt_d   = 5'd0;
            state_d = ST_SEND_PAT;
          end
        end
`ifdef SME_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          res_valid_d = 1'b1;
          res_d       = '{match: 1'b0, index: 5'd0, pidx: pidx_q, timeout: 1'b1};
          state_d     = ST_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    isstring_d  = (state_d == ST_SEND_STR);
    ispattern_d = (state_d == ST_SEND_PAT);
    chardata_d  = isstring_d  ? str_rdata :
                  ispattern_d ? pat_rdata : '0;
    busy_d      = (state_d == ST_SEND_STR) || (state_d == ST_SEND_PAT) ||
                  (state_d == ST_WAIT_RES);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cfg_q     <= '0;
      cnt_q     <= '0;
      pidx_q    <= '0;
      res_q     <= '0;
      res_valid <= 1'b0;
      chardata  <= '0;
      isstring  <= 1'b0;
      ispattern <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
`ifdef SME_TIMEOUT_EN
      wd_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      cnt_q     <= cnt_d;
      pidx_q    <= pidx_d;
      res_q     <= res_d;
      res_valid <= res_valid_d;
      chardata  <= chardata_d;
      isstring  <= isstring_d;
      ispattern <= ispattern_d;
      busy      <= busy_d;
      done      <= done_d;
      cfg_err   <= cfg_err_d;
`ifdef SME_TIMEOUT_EN
      wd_q      <= wd_d;
`endif
    end
  end

  assign res_match   = res_q.match;
  assign res_index   = res_q.index;
  assign res_pidx    = res_q.pidx;
  assign res_timeout = res_q.timeout;

endmodule

// File: tb/tb_sme_job_sender.sv
// Bench for sme_job_sender: directed jobs, a behavioural model that predicts the
// char stream, results and status from the inputs, plus literal spot checks.
module tb_sme_job_sender;

  localparam int NPAT    = 4;
  localparam int TIMEOUT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_we, ld_sel;
  logic [1:0]  ld_pidx;
  logic [4:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        start;
  logic [5:0]  str_len;
  logic [2:0]  num_pat;
  logic [15:0] pat_len;
  logic [7:0]  chardata;
  logic        isstring, ispattern;
  logic        valid, match;
  logic [4:0]  match_index;
  logic        res_valid, res_match, res_timeout;
  logic [4:0]  res_index;
  logic [1:0]  res_pidx;
  logic        busy, done, cfg_err;

  sme_job_sender #(.STR_MAX(32), .PAT_MAX(8), .NPAT(NPAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ld_we(ld_we), .ld_sel(ld_sel), .ld_pidx(ld_pidx), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .str_len(str_len), .num_pat(num_pat), .pat_len(pat_len),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .valid(valid), .match(match), .match_index(match_index),
    .res_valid(res_valid), .res_match(res_match), .res_index(res_index),
    .res_pidx(res_pidx), .res_timeout(res_timeout),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit sim_done = 0;

  // model state
  logic [9:0] exp_q[$];     // {isstring, ispattern, char} expected per streaming cycle
  logic [9:0] slog[$];      // every strobed char seen
  logic [1:0] rlog[$];      // res_pidx of every result seen
  logic [7:0] m_str[32];
  logic [7:0] m_pat[4][8];
  bit         m_active;
  int         m_npat, m_pidx, m_wcnt;
  int         m_plen[4];
  logic       p_res_valid, p_done, p_cfg_err, p_busy;
  logic [8:0] p_res;        // {match, index, pidx, timeout}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cfg_ok();
    int l;
    if (str_len < 1 || str_len > 32) return 0;
    if (num_pat < 1 || num_pat > NPAT) return 0;
    for (int k = 0; k < NPAT; k++) begin
      l = int'(pat_len[4*k +: 4]);
      if (k < int'(num_pat) && (l < 1 || l > 8)) return 0;
    end
    return 1;
  endfunction

  task automatic push_pat(input int k);
    for (int i = 0; i < m_plen[k]; i++) exp_q.push_back({2'b01, m_pat[k][i]});
  endtask

  task automatic finish_result();
    if (m_pidx == m_npat - 1) begin
      m_active = 0;
      p_done   = 1;
    end else begin
      m_pidx++;
      m_wcnt = 0;
      push_pat(m_pidx);
    end
  endtask

  // Called every falling edge: check this cycle against last cycle's
  // prediction, then predict the next cycle from this cycle's inputs.
  task automatic monitor_cycle();
    bit in_wait, was_done;
    logic [9:0] e;
    if (reset) begin
      chk("reset_outputs", {chardata, isstring, ispattern, res_valid, res_match, res_index,
                            res_pidx, res_timeout, busy, done, cfg_err}, 32'd0);
      exp_q.delete();
      m_active = 0;
      p_res_valid = 0; p_done = 0; p_cfg_err = 0; p_busy = 0;
    end else begin
      in_wait = m_active && (exp_q.size() == 0);
      if (isstring || ispattern) slog.push_back({isstring, ispattern, chardata});
      if (res_valid) rlog.push_back(res_pidx);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("char_stream", {isstring, ispattern, chardata}, e);
      end else begin
        chk("no_strobe", {isstring, ispattern, chardata}, 32'd0);
      end
      chk("res_valid", res_valid, p_res_valid);
      if (p_res_valid) chk("result", {res_match, res_index, res_pidx, res_timeout}, p_res);
      chk("done", done, p_done);
      chk("busy", busy, p_busy);
      chk("cfg_err", cfg_err, p_cfg_err);

      was_done = p_done;
      p_res_valid = 0; p_done = 0; p_cfg_err = 0;
      if (ld_we && !m_active) begin
        if (!ld_sel) m_str[ld_addr] = ld_data;
        else if (int'(ld_pidx) < NPAT) m_pat[ld_pidx][ld_addr[2:0]] = ld_data;
      end
      if (start && !m_active && !was_done) begin
        if (cfg_ok()) begin
          m_active = 1;
          m_npat   = int'(num_pat);
          for (int k = 0; k < 4; k++) m_plen[k] = int'(pat_len[4*k +: 4]);
          for (int i = 0; i < int'(str_len); i++) exp_q.push_back({2'b10, m_str[i]});
          m_pidx = 0;
          m_wcnt = 0;
          push_pat(0);
        end else begin
          p_cfg_err = 1;
        end
      end else if (in_wait) begin
        if (valid) begin
          p_res_valid = 1;
          p_res = {match, match_index, 2'(m_pidx), 1'b0};
          finish_result();
        end
`ifdef SME_TIMEOUT_EN
        else begin
          m_wcnt++;
          if (m_wcnt == TIMEOUT) begin
            p_res_valid = 1;
            p_res = {1'b0, 5'd0, 2'(m_pidx), 1'b1};
            m_active = 0;
            p_done = 1;
          end
        end
`endif
      end
      p_busy = m_active;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      ld_we = 1; ld_sel = 0; ld_addr = 5'(i); ld_data = s[i];
      step(1);
    end
    ld_we = 0;
  endtask

  task automatic load_pat(input int k, input string s);
    for (int i = 0; i < s.len(); i++) begin
      ld_we = 1; ld_sel = 1; ld_pidx = 2'(k); ld_addr = 5'(i); ld_data = s[i];
      step(1);
    end
    ld_we = 0;
  endtask

  // Returns in the first cycle after the start edge.
  task automatic start_job(input int sl, input int np, input logic [15:0] pl);
    start = 1; str_len = 6'(sl); num_pat = 3'(np); pat_len = pl;
    step(1);
    start = 0;
  endtask

  task automatic pulse_valid(input logic m, input logic [4:0] idx);
    valid = 1; match = m; match_index = idx;
    step(1);
    valid = 0; match = 0; match_index = 0;
  endtask

  logic [9:0] t1_exp [6];
  int base, base_r, nstr;

  initial begin
    reset = 1; ld_we = 0; ld_sel = 0; ld_pidx = 0; ld_addr = 0; ld_data = 0;
    start = 0; str_len = 0; num_pat = 0; pat_len = 0; valid = 0; match = 0; match_index = 0;
    t1_exp = '{10'h261, 10'h262, 10'h263, 10'h264, 10'h162, 10'h163};
    fork
      begin
        while (!sim_done) begin
          @(negedge clk);
          if (!sim_done) monitor_cycle();
        end
      end
      begin
        step(3);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        reset = 0;
        step(2);

        // 1: "abcd" with pattern "bc"; a stray valid during the last pattern char is ignored
        load_str("abcd");
        load_pat(0, "bc");
        step(1);
        base = slog.size(); base_r = rlog.size();
        start_job(4, 1, 16'h0002);
        step(5);
        valid = 1; match = 0; match_index = 5'd7;
        step(1);
        pulse_valid(1, 5'd1);
        chk("t1_res_valid", res_valid, 1);
        chk("t1_res_match", res_match, 1);
        chk("t1_res_index", res_index, 5'd1);
        chk("t1_res_pidx", res_pidx, 0);
        chk("t1_done", done, 1);
        step(2);
        chk("t1_nchars", slog.size() - base, 6);
        for (int i = 0; i < 6; i++)
          if (base + i < slog.size()) chk("t1_char", slog[base + i], t1_exp[i]);

        // 2: three patterns, one with a longer wait for valid; string sent once
        load_pat(1, "xyz");
        load_pat(2, "a");
        step(1);
        base = slog.size(); base_r = rlog.size();
        start_job(4, 3, 16'h0132);
        step(6);
        step(3);
        pulse_valid(1, 5'd3);
        step(3);
        pulse_valid(0, 5'd0);
        step(1);
        pulse_valid(1, 5'd31);
        chk("t2_done", done, 1);
        step(2);
        nstr = 0;
        for (int i = base; i < slog.size(); i++) if (slog[i][9]) nstr++;
        chk("t2_string_once", nstr, 4);
        chk("t2_nres", rlog.size() - base_r, 3);
        for (int i = 0; i < 3; i++)
          if (base_r + i < rlog.size()) chk("t2_res_pidx", rlog[base_r + i], i);

        // 3: illegal configurations are rejected
        base = slog.size();
        start_job(0, 1, 16'h0002);
        chk("t3_cfg_err", cfg_err, 1);
        chk("t3_busy", busy, 0);
        step(2);
        start_job(33, 1, 16'h0002);  chk("t3_len33", cfg_err, 1);  step(1);
        start_job(4, 0, 16'h0002);   chk("t3_npat0", cfg_err, 1);  step(1);
        start_job(4, 5, 16'h2222);   chk("t3_npat5", cfg_err, 1);  step(1);
        start_job(4, 2, 16'h0092);   chk("t3_plen9", cfg_err, 1);  step(1);
        start_job(4, 2, 16'h0002);   chk("t3_plen0", cfg_err, 1);  step(2);
        chk("t3_no_strobes", slog.size() - base, 0);

        // 4: loads and start while busy are ignored
        start_job(4, 1, 16'h0002);
        ld_we = 1; ld_sel = 0; ld_addr = 0; ld_data = 8'h5A;
        start = 1; str_len = 6'd2;
        step(2);
        ld_we = 0; start = 0;
        step(4);
        pulse_valid(0, 5'd0);
        step(2);
        base = slog.size();
        start_job(4, 1, 16'h0002);
        step(6);
        pulse_valid(1, 5'd2);
        step(2);
        chk("t4_buf_kept", (base < slog.size()) ? slog[base] : 10'h0, 10'h261);

        // 5: reset in the middle of a pattern burst
        base_r = rlog.size();
        start_job(4, 1, 16'h0002);
        step(4);
        chk("t5_pre_ispattern", ispattern, 1);
        reset = 1;
        #2;
        chk("t5_ispattern", ispattern, 0);
        chk("t5_chardata", chardata, 0);
        step(2);
        reset = 0;
        pulse_valid(1, 5'd4);
        step(5);
        chk("t5_no_result", rlog.size() - base_r, 0);

        // 6: engine never answers
        base_r = rlog.size();
        start_job(4, 1, 16'h0002);
        step(6);
`ifdef SME_TIMEOUT_EN
        step(10);
        chk("t6_res_valid", res_valid, 1);
        chk("t6_res_timeout", res_timeout, 1);
        chk("t6_res_match", res_match, 0);
        chk("t6_done", done, 1);
        step(2);
`else
        step(30);
        chk("t6_busy_held", busy, 1);
        chk("t6_no_result", rlog.size() - base_r, 0);
        reset = 1;
        step(2);
        reset = 0;
        step(2);
`endif

        // boundary: 32-char string, four patterns of lengths 1,1,1,8
        for (int i = 0; i < 32; i++) begin
          ld_we = 1; ld_sel = 0; ld_addr = 5'(i); ld_data = 8'(8'h41 + i);
          step(1);
        end
        ld_we = 0;
        load_pat(3, "ABCDEFGH");
        step(1);
        base = slog.size(); base_r = rlog.size();
        start_job(32, 4, 16'h8111);
        step(33);
        pulse_valid(1, 5'd10);
        step(1);
        pulse_valid(0, 5'd0);
        step(1);
        pulse_valid(1, 5'd20);
        step(8);
        pulse_valid(1, 5'd24);
        chk("bnd_pidx", res_pidx, 2'd3);
        chk("bnd_done", done, 1);
        step(2);
        chk("bnd_nchars", slog.size() - base, 43);
        chk("bnd_last_str", (base + 31 < slog.size()) ? slog[base + 31] : 10'h0, 10'h260);

        sim_done = 1;
      end
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
